// File: rtl/toaster_lcd_writer.sv
// Toaster status writer for an HD44780-compatible 16x2 LCD: power-up delay, init, and 35-byte redraws.
// Optional macro TOASTER_LCD_TIME_EN adds time_digit and shows "T<digit>" in line-2 columns 14..15.
module toaster_lcd_writer #(
   parameter int POWERUP_CYC    = 750000,
   parameter int EN_PULSE_CYC   = 25,
   parameter int CMD_WAIT_CYC   = 2500,
   parameter int CLEAR_WAIT_CYC = 100000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [2:0] state_code,
   input  logic       refresh,
`ifdef TOASTER_LCD_TIME_EN
   input  logic [3:0] time_digit,
`endif
   output logic       busy,
   output logic       done,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_EN,
   output logic       LCD_RW,
   output logic       LCD_ON,
   output logic       LCD_BLON
);

   localparam int MAX_A   = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
   localparam int MAX_B   = (CMD_WAIT_CYC > EN_PULSE_CYC) ? CMD_WAIT_CYC : EN_PULSE_CYC;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYC - 1);
   localparam logic [CW-1:0] EN_LAST    = CW'(EN_PULSE_CYC - 1);
   localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
   localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);

   typedef enum logic [3:0] {
      S_PWRUP, S_INIT, S_IDLE, S_CLEAR, S_L1ADDR, S_L1TXT, S_L2ADDR, S_L2TXT, S_FIN
   } state_t;

   typedef enum logic [1:0] {P_SETUP, P_EN, P_WAIT} phase_t;

   state_t         state_reg, state_next;
   phase_t         phase_reg, phase_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic [3:0]     idx_reg, idx_next;
   logic [2:0]     code_reg, code_next;
   logic           pending_reg, pending_next;
   logic           busy_reg, busy_next;
   logic           done_reg, done_next;
   logic           en_reg, en_next;

   logic [127:0]   l1_line, l2_line;
   logic [7:0]     l1_bytes [16];
   logic [7:0]     l2_bytes [16];
   logic [7:0]     byte_val;
   logic           rs_val;
   logic           is_clear;
   logic [CW-1:0]  wait_last;
   logic           byte_done;

   // Message text, first character in the most significant byte.
   function automatic logic [127:0] line1_text(input logic [2:0] c);
      case (c)
         3'd0:    line1_text = {"DESLIGADO",       {7{8'h20}}};
         3'd1:    line1_text = {"LIGADO",          {10{8'h20}}};
         3'd2:    line1_text = {"PREPARANDO",      {6{8'h20}}};
         3'd3:    line1_text = {"PRONTO",          {10{8'h20}}};
         3'd4:    line1_text = {"QUEIMANDO!",      {6{8'h20}}};
         3'd5:    line1_text = {"BOM APETITE",     {5{8'h20}}};
         default: line1_text = {"ESTADO INVALIDO", {1{8'h20}}};
      endcase
   endfunction

   function automatic logic [127:0] line2_text(input logic [2:0] c);
      case (c)
         3'd0:    line2_text = {"TORRADEIRA",      {6{8'h20}}};
         3'd1:    line2_text = {"ESCOLHA O TEMPO", {1{8'h20}}};
         3'd2:    line2_text = {"AGUARDE",         {9{8'h20}}};
         3'd3:    line2_text = {"RETIRE O PAO",    {4{8'h20}}};
         3'd4:    line2_text = {"RETIRE JA",       {7{8'h20}}};
         3'd5:    line2_text = {"SW0 DESLIGA",     {5{8'h20}}};
         default: line2_text = {16{8'h20}};
      endcase
   endfunction

   assign l1_line = line1_text(code_reg);
   assign l2_line = line2_text(code_reg);

`ifdef TOASTER_LCD_TIME_EN
   logic [3:0] time_reg, time_next;
   logic [7:0] time_char;
   assign time_char = (time_reg < 4'd10) ? (8'h30 + {4'h0, time_reg}) : 8'h2A;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_col
         assign l1_bytes[gi] = l1_line[127 - 8*gi -: 8];
`ifdef TOASTER_LCD_TIME_EN
         if (gi == 14) begin : g_t
            assign l2_bytes[gi] = 8'h54;
         end else if (gi == 15) begin : g_d
            assign l2_bytes[gi] = time_char;
         end else begin : g_txt
            assign l2_bytes[gi] = l2_line[127 - 8*gi -: 8];
         end
`else
         assign l2_bytes[gi] = l2_line[127 - 8*gi -: 8];
`endif
      end
   endgenerate

   // Byte presented on the bus; stays stable for the whole setup/pulse/wait of one byte.
   always_comb begin
      byte_val = 8'h00;
      rs_val   = 1'b0;
      case (state_reg)
         S_INIT: begin
            case (idx_reg[1:0])
               2'd0:    byte_val = 8'h38;
               2'd1:    byte_val = 8'h0C;
               2'd2:    byte_val = 8'h06;
               default: byte_val = 8'h01;
            endcase
         end
         S_CLEAR:  byte_val = 8'h01;
         S_L1ADDR: byte_val = 8'h80;
         S_L1TXT: begin
            byte_val = l1_bytes[idx_reg];
            rs_val   = 1'b1;
         end
         S_L2ADDR: byte_val = 8'hC0;
         S_L2TXT: begin
            byte_val = l2_bytes[idx_reg];
            rs_val   = 1'b1;
         end
         default: ;
      endcase
   end

   assign is_clear  = !rs_val && (byte_val == 8'h01);
   assign wait_last = is_clear ? CLEAR_LAST : CMD_LAST;

   always_comb begin
      state_next   = state_reg;
      phase_next   = phase_reg;
      cnt_next     = cnt_reg;
      idx_next     = idx_reg;
      code_next    = code_reg;
      byte_done    = 1'b0;
      pending_next = pending_reg | refresh;
`ifdef TOASTER_LCD_TIME_EN
      time_next    = time_reg;
      if (state_reg == S_IDLE && time_digit != time_reg)
         pending_next = 1'b1;
`endif

      case (state_reg)
         S_PWRUP: begin
            if (cnt_reg == PWR_LAST) begin
               state_next = S_INIT;
               phase_next = P_SETUP;
               cnt_next   = '0;
               idx_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         S_IDLE: begin
            // Sampling here means the newest code wins and any strobes so far are absorbed.
            if (pending_reg) begin
               code_next    = state_code;
`ifdef TOASTER_LCD_TIME_EN
               time_next    = time_digit;
`endif
               pending_next = 1'b0;
               state_next   = S_CLEAR;
               phase_next   = P_SETUP;
               cnt_next     = '0;
            end
         end
         S_FIN: state_next = S_IDLE;
         default: begin
            case (phase_reg)
               P_SETUP: begin
                  phase_next = P_EN;
                  cnt_next   = '0;
               end
               P_EN: begin
                  if (cnt_reg == EN_LAST) begin
                     phase_next = P_WAIT;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_reg + CW'(1);
                  end
               end
               default: begin
                  if (cnt_reg == wait_last) begin
                     byte_done  = 1'b1;
                     phase_next = P_SETUP;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_reg + CW'(1);
                  end
               end
            endcase

            if (byte_done) begin
               case (state_reg)
                  S_INIT: begin
                     if (idx_reg == 4'd3) begin
                        state_next = S_IDLE;
                        idx_next   = '0;
                     end else begin
                        idx_next = idx_reg + 4'd1;
                     end
                  end
                  S_CLEAR:  state_next = S_L1ADDR;
                  S_L1ADDR: begin
                     state_next = S_L1TXT;
                     idx_next   = '0;
                  end
                  S_L1TXT: begin
                     if (idx_reg == 4'd15) state_next = S_L2ADDR;
                     else                  idx_next   = idx_reg + 4'd1;
                  end
                  S_L2ADDR: begin
                     state_next = S_L2TXT;
                     idx_next   = '0;
                  end
                  S_L2TXT: begin
                     if (idx_reg == 4'd15) state_next = S_FIN;
                     else                  idx_next   = idx_reg + 4'd1;
                  end
                  default: ;
               endcase
            end
         end
      endcase

      done_next = (state_next == S_FIN);
      busy_next = !((state_next == S_IDLE) && !pending_next);
      en_next   = (phase_next == P_EN);
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_reg   <= S_PWRUP;
         phase_reg   <= P_SETUP;
         cnt_reg     <= '0;
         idx_reg     <= '0;
         code_reg    <= 3'd0;
         pending_reg <= 1'b1;
         busy_reg    <= 1'b1;
         done_reg    <= 1'b0;
         en_reg      <= 1'b0;
`ifdef TOASTER_LCD_TIME_EN
         time_reg    <= 4'd0;
`endif
      end else begin
         state_reg   <= state_next;
         phase_reg   <= phase_next;
         cnt_reg     <= cnt_next;
         idx_reg     <= idx_next;
         code_reg    <= code_next;
         pending_reg <= pending_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         en_reg      <= en_next;
`ifdef TOASTER_LCD_TIME_EN
         time_reg    <= time_next;
`endif
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign LCD_EN   = en_reg;
   assign LCD_RS   = rs_val;
   assign LCD_DATA = byte_val;
   assign LCD_RW   = 1'b0;
   assign LCD_ON   = 1'b1;
   assign LCD_BLON = 1'b1;

endmodule

// File: doc/toaster_lcd_writer.md
Name: toaster_lcd_writer

Overview:
- Display-side responder for the toaster controller's state/refresh interface.
- Takes the 3-bit toaster state code and a one-cycle refresh strobe, then writes a fixed 2x16 status message to the HD44780-compatible 16x2 LCD through its 8-bit write-only bus.
- Owns power-up delay, controller init sequence, and all EN/RS timing.
- Sits between the toaster FSM and the LCD pins.

Parameters:
- POWERUP_CYC, 750000, cycles to wait after reset before first command (15 ms at 50 MHz).
- EN_PULSE_CYC, 25, cycles LCD_EN is held high per byte (500 ns).
- CMD_WAIT_CYC, 2500, post-byte wait for normal commands and data (50 us).
- CLEAR_WAIT_CYC, 100000, post-byte wait after 0x01 clear (2 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  reset, asynchronous, active-low
- state_code  in  3  toaster state: 0 desligado, 1 ligado, 2 preparo, 3 pronto, 4 queimando, 5 bomApetite
- refresh  in  1  one-cycle request to redraw for current state_code
- busy  out  1  high from reset until current/pending redraw completes
- done  out  1  one-cycle pulse when a redraw finishes
- LCD_DATA  out  8  LCD data bus
- LCD_RS  out  1  0 command, 1 data
- LCD_EN  out  1  LCD enable strobe
- LCD_RW  out  1  constant 0 (write only)
- LCD_ON  out  1  constant 1
- LCD_BLON  out  1  constant 1

Behaviour:
- Reset (async, any time, including mid-byte):
  - LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, done=0, busy=1, pending=1.
  - Latched code=0; FSM returns to PWRUP.
- Byte write, identical for every byte:
  - 1 setup cycle: RS/DATA driven, EN=0.
  - EN=1 for EN_PULSE_CYC cycles.
  - EN=0; RS/DATA held for the wait count.
  - Wait count is CLEAR_WAIT_CYC after byte 0x01 with RS=0, otherwise CMD_WAIT_CYC.
- FSM states:
  - PWRUP: count POWERUP_CYC, then INIT.
  - INIT: commands 0x38, 0x0C, 0x06, 0x01 in order, then IDLE.
  - IDLE: if pending, latch state_code, clear pending, go to CLEAR.
  - CLEAR: command 0x01.
  - L1ADDR: command 0x80.
  - L1TXT: 16 data bytes.
  - L2ADDR: command 0xC0.
  - L2TXT: 16 data bytes.
  - FIN: pulse done for 1 cycle, go to IDLE.
- A redraw is exactly 35 bytes.
- busy=0 only in IDLE with pending=0.
- Messages (line 1 / line 2), ASCII, left-justified, space padded to 16:
  - 0: "DESLIGADO" / "TORRADEIRA"
  - 1: "LIGADO" / "ESCOLHA O TEMPO"
  - 2: "PREPARANDO" / "AGUARDE"
  - 3: "PRONTO" / "RETIRE O PAO"
  - 4: "QUEIMANDO!" / "RETIRE JA"
  - 5: "BOM APETITE" / "SW0 DESLIGA"
  - 6, 7: "ESTADO INVALIDO" / all spaces
- Refresh timing:
  - Refresh sets pending in any state; multiple strobes while busy coalesce into one.
  - A strobe arriving in the same cycle that FIN→IDLE occurs is not lost.
  - The code is sampled on leaving IDLE, so the newest state_code is used. Changes to state_code mid-redraw do not affect the current message.
- Init auto-refresh: the first redraw after INIT is automatic (pending=1 from reset) and shows state 0 unless state_code differs at latch time.
- All counters are sized for the largest parameter; no wrap-around within a count.

Optional Feature:
- Macro: TOASTER_LCD_TIME_EN.
- Defined:
  - Adds input time_digit[3:0].
  - Line-2 columns 14..15 show "T" followed by the digit (ASCII 0x30+value; values 10-15 show '*').
  - time_digit is latched with state_code.
  - A change in time_digit while idle sets pending automatically.
- Undefined: the port is absent and line 2 is exactly as tabulated.

Test Plan:
Simulation parameters: POWERUP_CYC=20, EN_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8.
- Reset release, state_code=0 → no EN pulse before cycle 20; bytes 0x38, 0x0C, 0x06, 0x01 with RS=0; then a 35-byte redraw "DESLIGADO"/"TORRADEIRA"; done pulses once; busy falls.
- Idle, state_code=3, refresh 1 cycle → 0x01, 0x80, "PRONTO"+10 spaces (RS=1), 0xC0, "RETIRE O PAO"+4 spaces. Each EN high exactly 2 cycles; gap after 0x01 is 8 cycles, others 4.
- Refresh with code 2; during L1TXT set code 4 and strobe refresh 3 times → first redraw completes with "PREPARANDO"; exactly one further redraw "QUEIMANDO!"; done pulses twice total.
- state_code=7, refresh → line 1 "ESTADO INVALIDO"+1 space, line 2 16 spaces (0x20).
- Assert reset while LCD_EN=1 mid-L2TXT → EN drops to 0 asynchronously; busy=1; full PWRUP+INIT sequence restarts after release.
- TOASTER_LCD_TIME_EN defined: code 2, time_digit=5, refresh → line-2 bytes 14..15 = 0x54, 0x35. Then change time_digit to 4 while idle → automatic redraw with 0x34.
